pipeline_skid_reg: RTL and testbench

Parametrised elastic pipeline register for the GPU datapath, replacing plain enable-gated stage registers wherever back-pressure must propagate between units. The block is a chain of `STAGES` skid-buffered slots carrying a `WIDTH`-bit payload under a valid/ready handshake. It sustains one beat per cycle, registers the upstream ready signal and supports a synchronous pipeline flush. It sits between producer and consumer units such as fetch→decode and execute→writeback.

---
 rtl/pipeline_skid_reg_pkg.sv | 23 ++
 rtl/pipeline_skid_reg_if.sv | 39 +++
 rtl/pipeline_skid_reg_skid_slot.sv | 116 +++++++++++
 rtl/pipeline_skid_reg.sv | 93 +++++++++
 tb/tb_pipeline_skid_reg.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pipe_pkg
// Shared types and constants for the elastic pipeline register.
//   skid_state_t     : per-slot occupancy state (EMPTY / ONE / TWO)
//   PIPE_MAX_STAGES  : largest supported STAGES value
//   occ_width()      : bit width of the occupancy counter for a given STAGES
// -----------------------------------------------------------------------------
package gpu_pipe_pkg;

  localparam int unsigned PIPE_MAX_STAGES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Each slot holds up to two beats, so the counter must represent 0..2*stages.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage : gpu_pipe_pkg

// File: rtl/pipeline_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipeline_skid_reg_if
// Valid/ready handshake bundle for both sides of the elastic pipeline register.
//   in_valid / in_data / in_ready    : upstream (producer) side
//   out_valid / out_data / out_ready : downstream (consumer) side
// Modports:
//   master : the environment (drives upstream beats, drives downstream ready)
//   slave  : the pipeline register itself
// -----------------------------------------------------------------------------
interface pipeline_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface : pipeline_skid_reg_if

// File: rtl/pipeline_skid_reg_skid_slot.sv
// -----------------------------------------------------------------------------
// skid_slot
// One skid-buffered pipeline slot: a main register (the output) plus a skid
// register that catches the beat accepted in the cycle downstream stalls.
// Upstream ready is purely registered (it is just "skid not full").
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : synchronous flush to EMPTY, overrides any transfer
//   i_valid, i_data, o_ready : upstream handshake
//   o_valid, o_data, i_ready : downstream handshake
// Optional macro PIPE_SKID_DATA_CLEAR_EN: data registers reset/flush to zero
// and o_data is forced to zero while o_valid is low.
// -----------------------------------------------------------------------------
module skid_slot
  import gpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign o_ready    = (r_state != TWO);
  assign o_valid    = (r_state != EMPTY);
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = o_valid && i_ready;

`ifdef PIPE_SKID_DATA_CLEAR_EN
  assign o_data = o_valid ? r_main : '0;
`else
  assign o_data = r_main;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      w_state_nxt = EMPTY;
`ifdef PIPE_SKID_DATA_CLEAR_EN
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
`endif
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = i_data;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = i_data;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
          end else if (w_in_xfer) begin
            // Downstream stalled this cycle: park the new beat in the skid.
            w_state_nxt = TWO;
            w_skid_nxt  = i_data;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef PIPE_SKID_DATA_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      r_main <= w_main_nxt;
      r_skid <= w_skid_nxt;
    end
  end
`else
  // Data path carries no reset; only the state flops decide validity.
  always_ff @(posedge clk) begin
    r_main <= w_main_nxt;
    r_skid <= w_skid_nxt;
  end
`endif

endmodule : skid_slot

// File: rtl/pipeline_skid_reg.sv
// -----------------------------------------------------------------------------
// pipeline_skid_reg
// Elastic pipeline register: STAGES chained skid slots carrying a WIDTH-bit
// payload under valid/ready, full throughput, registered upstream ready,
// synchronous flush and a beat occupancy counter.
// Parameters:
//   WIDTH  : payload width (>= 1)
//   STAGES : number of chained slots (1..PIPE_MAX_STAGES)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous flush of every slot; input beat that cycle dropped
//   bus        : handshake bundle (slave modport), in_* upstream, out_* downstream
//   occupancy  : beats currently held, 0..2*STAGES
// Optional macro PIPE_SKID_DATA_CLEAR_EN: data registers reset and flush to
// zero and out_data reads zero while out_valid is low.
// -----------------------------------------------------------------------------
module pipeline_skid_reg
  import gpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  pipeline_skid_reg_if.slave             bus,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int unsigned OccW = occ_width(STAGES);

  // Chain nodes: index k is the input side of slot k, index STAGES is the output.
  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic [WIDTH-1:0] w_data  [STAGES+1];

  assign w_valid[0]      = bus.in_valid;
  assign w_data[0]       = bus.in_data;
  assign bus.in_ready    = w_ready[0];
  assign bus.out_valid   = w_valid[STAGES];
  assign bus.out_data    = w_data[STAGES];
  assign w_ready[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    skid_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .o_ready (w_ready[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .i_ready (w_ready[k+1])
    );
  end

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [OccW-1:0] r_occ;
  logic [OccW-1:0] w_occ_nxt;

  assign w_in_xfer  = bus.in_valid && bus.in_ready;
  assign w_out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = '0;
    end else begin
      w_occ_nxt = r_occ + OccW'(w_in_xfer) - OccW'(w_out_xfer);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign occupancy = r_occ;

  a_stages_range: assert property (@(posedge clk)
    (STAGES >= 1) && (STAGES <= PIPE_MAX_STAGES));

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_occ <= OccW'(2 * STAGES));

endmodule : pipeline_skid_reg

// File: tb/tb_pipeline_skid_reg.sv
module tb_pipeline_skid_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       fl_s1, fl_s2, fl_s3, fl_s4;
  logic [1:0] occ_s1;
  logic [2:0] occ_s2;
  logic [2:0] occ_s3;
  logic [3:0] occ_s4;

  pipeline_skid_reg_if #(.WIDTH(32)) bus_s1 ();
  pipeline_skid_reg_if #(.WIDTH(32)) bus_s2 ();
  pipeline_skid_reg_if #(.WIDTH(32)) bus_s3 ();
  pipeline_skid_reg_if #(.WIDTH(32)) bus_s4 ();

  pipeline_skid_reg #(.WIDTH(32), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(fl_s1), .bus(bus_s1), .occupancy(occ_s1));
  pipeline_skid_reg #(.WIDTH(32), .STAGES(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .flush(fl_s2), .bus(bus_s2), .occupancy(occ_s2));
  pipeline_skid_reg #(.WIDTH(32), .STAGES(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .flush(fl_s3), .bus(bus_s3), .occupancy(occ_s3));
  pipeline_skid_reg #(.WIDTH(32), .STAGES(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .flush(fl_s4), .bus(bus_s4), .occupancy(occ_s4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Table record: inputs for one cycle plus outputs expected during that cycle.
  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t tbl [13];

  // Reference model for the STAGES=4 instance: the block is a FIFO of beats.
  logic [31:0] q [$];
  logic        pend;
  logic [31:0] next_val;

  // mode 0: random traffic, 1: drain (no input, out_ready=1), 2: fill (out_ready=0)
  task automatic s4_cycle(input int mode);
    logic in_x, out_x;
    @(negedge clk);
    check("s4_occ_vs_model", occ_s4, q.size());
    check("s4_occ_bound", occ_s4 > 8, 0);
    if (q.size() == 0) begin
      check("s4_empty_out_valid", bus_s4.out_valid, 0);
      check("s4_empty_in_ready", bus_s4.in_ready, 1);
    end else if (bus_s4.out_valid) begin
      check("s4_out_data", bus_s4.out_data, q[0]);
    end
`ifdef PIPE_SKID_DATA_CLEAR_EN
    if (!bus_s4.out_valid) check("s4_data_clear", bus_s4.out_data, 0);
`endif
    if (mode == 1) begin
      bus_s4.in_valid  = 1'b0;
      bus_s4.out_ready = 1'b1;
    end else begin
      if (!pend) begin
        bus_s4.in_valid = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_s4.in_data  = next_val;
        next_val        = $urandom;
      end
      bus_s4.out_ready = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    in_x  = bus_s4.in_valid && bus_s4.in_ready;
    out_x = bus_s4.out_valid && bus_s4.out_ready;
    if (out_x && q.size() > 0) void'(q.pop_front());
    if (in_x) q.push_back(bus_s4.in_data);
    pend = bus_s4.in_valid && !bus_s4.in_ready;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcvd, t0, e0;
    bit full, seen;
    rst_n = 1'b0;
    {fl_s1, fl_s2, fl_s3, fl_s4} = '0;
    bus_s1.in_valid = 0; bus_s1.in_data = 0; bus_s1.out_ready = 0;
    bus_s2.in_valid = 0; bus_s2.in_data = 0; bus_s2.out_ready = 0;
    bus_s3.in_valid = 0; bus_s3.in_data = 0; bus_s3.out_ready = 0;
    bus_s4.in_valid = 0; bus_s4.in_data = 0; bus_s4.out_ready = 0;
    pend = 1'b0;
    next_val = $urandom;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_s1_in_ready", bus_s1.in_ready, 1);
    check("rst_s1_out_valid", bus_s1.out_valid, 0);
    check("rst_s1_occ", occ_s1, 0);
    check("rst_s3_in_ready", bus_s3.in_ready, 1);
    check("rst_s3_out_valid", bus_s3.out_valid, 0);
    check("rst_s4_occ", occ_s4, 0);
`ifdef PIPE_SKID_DATA_CLEAR_EN
    check("rst_s2_out_data", bus_s2.out_data, 0);
`endif
    rst_n = 1'b1;

    // ---------------- STAGES=1 table ----------------
    tbl[0]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 1};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 2};
    tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 2};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 1};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[6]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[7]  = '{1'b1, 32'hD, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 1};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[9]  = '{1'b1, 32'hE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[10] = '{1'b1, 32'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE, 1};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF, 1};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check($sformatf("s1_vec%0d_in_ready", i), bus_s1.in_ready, tbl[i].e_ir);
      check($sformatf("s1_vec%0d_out_valid", i), bus_s1.out_valid, tbl[i].e_ov);
      check($sformatf("s1_vec%0d_occ", i), occ_s1, tbl[i].e_occ);
      if (tbl[i].e_ov) check($sformatf("s1_vec%0d_out_data", i), bus_s1.out_data, tbl[i].e_od);
`ifdef PIPE_SKID_DATA_CLEAR_EN
      else check($sformatf("s1_vec%0d_data_clear", i), bus_s1.out_data, 0);
`endif
      bus_s1.in_valid  = tbl[i].vin;
      bus_s1.in_data   = tbl[i].din;
      bus_s1.out_ready = tbl[i].ordy;
      fl_s1            = tbl[i].fl;
    end
    @(negedge clk);
    bus_s1.in_valid = 1'b0;
    fl_s1 = 1'b0;

    // ---------------- STAGES=3 streaming ----------------
    sent = 0; rcvd = 0; t0 = -1;
    bus_s3.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_s3.out_valid) begin
        if (rcvd == 0) check("s3_latency_cycles", c - t0, 3);
        check($sformatf("s3_data%0d", rcvd), bus_s3.out_data, rcvd + 1);
        rcvd++;
      end
      if (t0 >= 0 && c >= t0 + 3 && c <= t0 + 15) check("s3_occ_steady", occ_s3, 3);
      if (sent < 16) check("s3_in_ready", bus_s3.in_ready, 1);
      bus_s3.in_valid = (sent < 16);
      bus_s3.in_data  = sent + 1;
      if (bus_s3.in_valid && bus_s3.in_ready) begin
        if (sent == 0) t0 = c;
        sent++;
      end
    end
    check("s3_received_all", rcvd, 16);
    check("s3_occ_drained", occ_s3, 0);
    bus_s3.in_valid = 1'b0;

    // ---------------- STAGES=2 flush ----------------
    full = 0; sent = 0;
    bus_s2.out_ready = 1'b0;
    for (int k = 0; k < 20 && !full; k++) begin
      @(negedge clk);
      if (occ_s2 == 4) begin
        full = 1;
      end else begin
        bus_s2.in_valid = 1'b1;
        bus_s2.in_data  = 32'h100 + sent;
        if (bus_s2.in_ready) sent++;
      end
    end
    check("s2_filled", full, 1);
    check("s2_in_ready_full", bus_s2.in_ready, 0);
    bus_s2.in_valid = 1'b1;
    bus_s2.in_data  = 32'hFF;
    fl_s2 = 1'b1;
    @(negedge clk);
    check("s2_flush_out_valid", bus_s2.out_valid, 0);
    check("s2_flush_occ", occ_s2, 0);
    check("s2_flush_in_ready", bus_s2.in_ready, 1);
    fl_s2 = 1'b0;
    bus_s2.in_valid  = 1'b0;
    bus_s2.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_s2.out_valid) seen = 1;
    end
    check("s2_nothing_after_flush", seen, 0);

    // ---------------- STAGES=4 random ----------------
    e0 = errors;
    for (int c = 0; c < 10000 && (errors - e0) < 20; c++) s4_cycle(0);
    for (int c = 0; c < 60 && (q.size() != 0 || pend); c++) s4_cycle(1);
    s4_cycle(1);
    check("s4_drained_model", q.size(), 0);
    check("s4_drained_occ", occ_s4, 0);

    // ---------------- asynchronous reset mid-stream ----------------
    for (int c = 0; c < 40 && q.size() != 5; c++) s4_cycle(2);
    check("s4_fill_to_5", q.size(), 5);
    @(negedge clk);
    check("s4_occ_before_reset", occ_s4, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus_s4.out_valid, 0);
    check("arst_in_ready", bus_s4.in_ready, 1);
    check("arst_occ", occ_s4, 0);
`ifdef PIPE_SKID_DATA_CLEAR_EN
    check("arst_out_data", bus_s4.out_data, 0);
`endif
    q.delete();
    pend = 1'b0;
    bus_s4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("resume_in_ready", bus_s4.in_ready, 1);
    bus_s4.in_valid  = 1'b1;
    bus_s4.in_data   = 32'hBEEF;
    bus_s4.out_ready = 1'b1;
    if (bus_s4.in_ready) q.push_back(32'hBEEF);
    for (int c = 0; c < 8; c++) s4_cycle(1);
    check("resume_beat_out", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_skid_reg
